uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler_pkg.sv | 34 +++
 rtl/uart_tx_scheduler_rr_select.sv | 39 +++
 rtl/uart_tx_scheduler.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_tx_scheduler_pkg                                  |
// | Description : Shared types, constants and helpers for the UART       |
// |               transmit scheduler (FSM encoding, start timeout,       |
// |               default burst cap, saturating byte counter step).      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package uart_tx_scheduler_pkg;

  // Scheduler FSM encoding
  typedef enum logic [1:0] {
    ARB        = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  // Cycles the UART may take to raise is_transmitting after a start pulse
  localparam int c_START_TIMEOUT = 4;

  // Width of the start-timeout counter (must hold c_START_TIMEOUT-1)
  localparam int c_TO_CNT_W = 3;

  // Bytes one requester may send per grant unless overridden
  localparam int c_DEFAULT_MAX_BURST = 16;

  // Increment a byte counter, holding at 255 instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_select                                              |
// | Description : Combinational round-robin priority selector. The       |
// |               search starts one above i_last_owner and wraps; the    |
// |               result is one-hot with a valid flag.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_owner,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_valid
);

  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_req_hi;
  logic [NUM_REQ-1:0] w_pick_src;

  // Mask of indices strictly above the previous owner (first search window)
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign w_mask[gi] = (gi > int'(i_last_owner));
    end
  endgenerate

  // Requests above the last owner win; otherwise wrap to the full vector
  assign w_req_hi   = i_req & w_mask;
  assign w_pick_src = (|w_req_hi) ? w_req_hi : i_req;

  // Isolate the lowest set bit of the chosen window
  assign o_grant = w_pick_src & (~w_pick_src + NUM_REQ'(1));
  assign o_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_tx_scheduler                                      |
// | Description : Round-robin scheduler sharing one UART transmitter     |
// |               among NUM_REQ byte requesters, with per-grant burst    |
// |               cap, frame-end release and start-timeout detection.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = c_DEFAULT_MAX_BURST
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [8*NUM_REQ-1:0] req_byte,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 transmit,
  output logic [7:0]           tx_byte,
  input  logic                 is_transmitting,
  output logic                 start_error,
  output logic                 busy
);

  localparam int c_IDX_W = $clog2(NUM_REQ);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NUM_REQ-1:0]    r_grant;
  logic [NUM_REQ-1:0]    w_grant_nxt;
  logic [c_IDX_W-1:0]    r_last_owner;
  logic [c_IDX_W-1:0]    w_last_owner_nxt;
  logic [7:0]            r_burst;
  logic [7:0]            w_burst_nxt;
  logic                  r_last_flag;
  logic                  w_last_flag_nxt;
  logic [c_TO_CNT_W-1:0] r_to_cnt;
  logic [c_TO_CNT_W-1:0] w_to_cnt_nxt;

  logic [c_IDX_W-1:0]    w_owner;
  logic [7:0]            w_owner_byte;
  logic                  w_owner_req;
  logic                  w_owner_last;
  logic [NUM_REQ-1:0]    w_rr_grant;
  logic                  w_rr_valid;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_IDX_W)
  ) u_rr_select (
    .i_req        (req),
    .i_last_owner (r_last_owner),
    .o_grant      (w_rr_grant),
    .o_valid      (w_rr_valid)
  );

  // Decode the current owner's index and pending byte from the one-hot grant
  always_comb begin
    w_owner      = '0;
    w_owner_byte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_owner      = c_IDX_W'(i);
        w_owner_byte = req_byte[8*i +: 8];
      end
    end
  end

  assign w_owner_req  = |(req & r_grant);
  assign w_owner_last = |(req_last & r_grant);

  // Next-state and pulse outputs; the start pulse is issued from ISSUE only
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_owner_nxt = r_last_owner;
    w_burst_nxt      = r_burst;
    w_last_flag_nxt  = r_last_flag;
    w_to_cnt_nxt     = r_to_cnt;
    transmit         = 1'b0;
    tx_byte          = 8'h00;
    ack              = '0;
    start_error      = 1'b0;

    case (r_state)
      ARB: begin
        if (w_rr_valid && !is_transmitting) begin
          w_grant_nxt = w_rr_grant;
          w_burst_nxt = 8'h00;
          w_state_nxt = ISSUE;
        end
      end

      ISSUE: begin
        if (w_owner_req) begin
          transmit        = 1'b1;
          tx_byte         = w_owner_byte;
          ack             = r_grant;
          w_burst_nxt     = sat_inc8(r_burst);
          w_last_flag_nxt = w_owner_last;
          w_to_cnt_nxt    = '0;
          w_state_nxt     = WAIT_START;
        end else begin
          // Owner withdrew before its byte could be taken
          w_grant_nxt = '0;
          w_state_nxt = ARB;
        end
      end

      WAIT_START: begin
        if (is_transmitting) begin
          w_state_nxt = WAIT_DONE;
        end else if (r_to_cnt == c_TO_CNT_W'(c_START_TIMEOUT - 1)) begin
          start_error      = 1'b1;
          w_grant_nxt      = '0;
          w_last_owner_nxt = w_owner;
          w_state_nxt      = ARB;
        end else begin
          w_to_cnt_nxt = r_to_cnt + c_TO_CNT_W'(1);
        end
      end

      WAIT_DONE: begin
        if (!is_transmitting) begin
          if (!r_last_flag && w_owner_req && (int'(r_burst) < MAX_BURST)) begin
            w_state_nxt = ISSUE;
          end else begin
            w_grant_nxt      = '0;
            w_last_owner_nxt = w_owner;
            w_state_nxt      = ARB;
          end
        end
      end

      default: begin
        w_grant_nxt = '0;
        w_state_nxt = ARB;
      end
    endcase
  end

  // State and bookkeeping registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ARB;
      r_grant      <= '0;
      r_last_owner <= c_IDX_W'(NUM_REQ - 1);
      r_burst      <= 8'h00;
      r_last_flag  <= 1'b0;
      r_to_cnt     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_burst      <= w_burst_nxt;
      r_last_flag  <= w_last_flag_nxt;
      r_to_cnt     <= w_to_cnt_nxt;
    end
  end

  assign grant = r_grant;
  assign busy  = (r_state != ARB);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_uart_tx_scheduler                                   |
// | Description : Directed scoreboard bench for uart_tx_scheduler with   |
// |               reactive requester and UART transmitter models.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_uart_tx_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 3;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req;
  logic [3:0]  req_last;
  logic [31:0] req_byte;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        is_transmitting;
  logic        start_error;
  logic        busy;

  uart_tx_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST)
  ) u_dut (
    .clk             (clk),
    .rst             (rst_n),
    .req             (req),
    .req_last        (req_last),
    .req_byte        (req_byte),
    .ack             (ack),
    .grant           (grant),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .is_transmitting (is_transmitting),
    .start_error     (start_error),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  exp_t       sb[$];
  int         rq_len[NUM_REQ];
  int         rq_sent[NUM_REQ];
  int         rq_lmode[NUM_REQ];   // 0: never last, 1: every byte last, 2: last on final byte
  logic [7:0] rq_base[NUM_REQ];
  int         pend_idx = -1;
  int         uart_cnt = 0;
  int         busy_len = 4;
  bit         uart_en = 1'b1;
  int         cyc = 0;
  int         last_tx_cyc = -100;
  logic       prev_tx = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req();
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i]             = (rq_sent[i] < rq_len[i]);
      req_byte[8*i +: 8] = rq_base[i] + 8'(rq_sent[i]);
      req_last[i]        = (rq_lmode[i] == 1) ||
                           ((rq_lmode[i] == 2) && (rq_sent[i] == rq_len[i] - 1));
    end
  endtask

  task automatic setup_req(input int i, input int len, input logic [7:0] base, input int lmode);
    rq_len[i]   = len;
    rq_sent[i]  = 0;
    rq_base[i]  = base;
    rq_lmode[i] = lmode;
    drive_req();
  endtask

  task automatic push_exp(input int idx, input logic [7:0] data);
    sb.push_back('{idx, data});
  endtask

  task automatic clear_model();
    sb.delete();
    pend_idx        = -1;
    uart_cnt        = 0;
    is_transmitting = 1'b0;
    uart_en         = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      rq_len[i]   = 0;
      rq_sent[i]  = 0;
      rq_lmode[i] = 0;
      rq_base[i]  = 8'h00;
    end
    drive_req();
  endtask

  // One clock: sample outputs against the scoreboard, then advance the models
  task automatic tick();
    exp_t e;
    logic exp_serr;
    @(posedge clk);
    #1;
    cyc++;
    exp_serr = !uart_en && (cyc == last_tx_cyc + 4);
    check("start_error", 32'(start_error), 32'(exp_serr));
    if (transmit) begin
      check("tx_not_back_to_back", 32'(prev_tx), 0);
      if (sb.size() == 0) begin
        check("unexpected_transmit", 32'(transmit), 0);
      end else begin
        e = sb.pop_front();
        check("tx_byte", 32'(tx_byte), 32'(e.data));
        check("ack_at_tx", 32'(ack), 1 << e.idx);
        check("grant_at_tx", 32'(grant), 1 << e.idx);
      end
      last_tx_cyc = cyc;
    end else begin
      check("ack_idle", 32'(ack), 0);
    end
    prev_tx = transmit;
    if (pend_idx >= 0) rq_sent[pend_idx]++;
    pend_idx = -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack[i]) pend_idx = i;
    end
    if (transmit && uart_en) uart_cnt = busy_len;
    is_transmitting = (uart_cnt > 0);
    if (uart_cnt > 0) uart_cnt--;
    drive_req();
  endtask

  task automatic run_until_idle(input string tag, input int max_cycles);
    int n = 0;
    while ((sb.size() != 0 || busy || is_transmitting) && n < max_cycles) begin
      tick();
      n++;
    end
    check({tag, "_done_in_time"}, 32'(n < max_cycles), 1);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    req             = '0;
    req_last        = '0;
    req_byte        = '0;
    is_transmitting = 1'b0;

    // Reset state
    rst_n = 1'b0;
    clear_model();
    tick();
    tick();
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_transmit", 32'(transmit), 0);
    check("rst_tx_byte", 32'(tx_byte), 0);
    check("rst_ack", 32'(ack), 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_no_req", 32'(busy), 0);

    // Single requester
    busy_len = 10;
    push_exp(0, 8'hA5);
    setup_req(0, 1, 8'hA5, 1);
    tick();
    check("s1_latency_transmit", 32'(transmit), 1);
    repeat (10) tick();
    check("s1_grant_held", 32'(grant), 32'b0001);
    tick();
    check("s1_grant_released", 32'(grant), 0);
    check("s1_busy_low", 32'(busy), 0);
    run_until_idle("s1", 20);

    // Single requester re-granted after one ARB cycle
    busy_len = 2;
    push_exp(2, 8'h60);
    push_exp(2, 8'h61);
    setup_req(2, 2, 8'h60, 1);
    tick();
    repeat (3) tick();
    check("regrant_arb_gap", 32'(busy), 0);
    tick();
    check("regrant_transmit", 32'(transmit), 1);
    run_until_idle("regrant", 20);

    // Fairness: all four held, one byte per grant
    do_reset();
    busy_len = 3;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_REQ; i++) push_exp(i, 8'(16 * (i + 1) + r));
    end
    for (int i = 0; i < NUM_REQ; i++) setup_req(i, 2, 8'(16 * (i + 1)), 1);
    run_until_idle("fair", 200);

    // Burst cap of 3 with a competing requester
    do_reset();
    busy_len = 2;
    push_exp(2, 8'hC0);
    push_exp(2, 8'hC1);
    push_exp(2, 8'hC2);
    push_exp(1, 8'hB0);
    push_exp(2, 8'hC3);
    push_exp(2, 8'hC4);
    setup_req(2, 5, 8'hC0, 0);
    tick();
    check("burst_first_grant", 32'(grant), 32'b0100);
    setup_req(1, 1, 8'hB0, 1);
    run_until_idle("burst", 200);

    // Start timeout: UART never starts
    do_reset();
    uart_en = 1'b0;
    push_exp(0, 8'hD0);
    push_exp(1, 8'hE0);
    push_exp(0, 8'hD1);
    setup_req(0, 2, 8'hD0, 1);
    setup_req(1, 1, 8'hE0, 1);
    tick();
    check("to_first_grant", 32'(grant), 32'b0001);
    repeat (4) tick();
    check("to_start_error", 32'(start_error), 1);
    tick();
    check("to_grant_released", 32'(grant), 0);
    tick();
    check("to_next_served", 32'(grant), 32'b0010);
    run_until_idle("timeout", 100);

    // Reset in WAIT_DONE of a 4-byte frame
    do_reset();
    busy_len = 6;
    push_exp(3, 8'h30);
    setup_req(3, 4, 8'h30, 2);
    tick();
    check("mid_first_tx", 32'(transmit), 1);
    repeat (3) tick();
    check("mid_in_wait_done", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_grant", 32'(grant), 0);
    check("mid_rst_ack", 32'(ack), 0);
    check("mid_rst_transmit", 32'(transmit), 0);
    check("mid_rst_tx_byte", 32'(tx_byte), 0);
    check("mid_rst_start_error", 32'(start_error), 0);
    check("mid_rst_busy", 32'(busy), 0);
    clear_model();
    tick();
    tick();
    push_exp(0, 8'h40);
    push_exp(3, 8'h70);
    setup_req(0, 1, 8'h40, 1);
    setup_req(3, 1, 8'h70, 1);
    rst_n = 1'b1;
    tick();
    check("post_reset_winner", 32'(grant), 32'b0001);
    run_until_idle("post_reset", 60);

    // Withdrawal after the first byte with last=0
    busy_len = 5;
    push_exp(1, 8'h55);
    setup_req(1, 1, 8'h55, 0);
    tick();
    check("wd_transmit", 32'(transmit), 1);
    repeat (5) tick();
    check("wd_grant_held", 32'(grant), 32'b0010);
    tick();
    check("wd_grant_released", 32'(grant), 0);
    repeat (6) tick();
    check("wd_idle", 32'(busy), 0);
    check("wd_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
